rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter_pkg.sv | 25 ++
 rtl/rf_write_arbiter_rr_pick.sv | 42 ++++
 rtl/rf_write_arbiter.sv | 144 ++++++++++++++
 tb/tb_rf_write_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: FSM encoding,
// default widths and a helper for sizing requester index fields.
package rf_write_arbiter_pkg;

    // Default number of write requesters.
    localparam int unsigned NUM_REQ_DEF = 3;

    // Default register address width (32 registers).
    localparam int unsigned ADDR_W_DEF = 5;

    // Default register data width.
    localparam int unsigned DATA_W_DEF = 32;

    // Arbiter FSM encoding.
    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // Width needed to hold a requester index (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the lowest set mask bit at or
// above ptr, wrapping to the lowest set bit overall when none is found.
module rr_pick #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic               upper_hit_c;
    logic [IDX_W-1:0]   upper_idx_c;
    logic               lower_hit_c;
    logic [IDX_W-1:0]   lower_idx_c;

    // Upward search from ptr, and a wrap-around search from bit 0.
    always_comb begin
        upper_hit_c = 1'b0;
        upper_idx_c = '0;
        lower_hit_c = 1'b0;
        lower_idx_c = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!upper_hit_c && mask[i] && (IDX_W'(i) >= ptr)) begin
                upper_hit_c = 1'b1;
                upper_idx_c = IDX_W'(i);
            end
            if (!lower_hit_c && mask[i]) begin
                lower_hit_c = 1'b1;
                lower_idx_c = IDX_W'(i);
            end
        end
    end

    // Prefer the candidate at/above ptr; fall back to the wrapped one.
    always_comb begin
        valid = upper_hit_c | lower_hit_c;
        idx   = upper_hit_c ? upper_idx_c : lower_idx_c;
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: round-robin grants one requester per cycle,
// drives a one-hot register load enable, the broadcast write data and a
// one-cycle ACK back to the winning requester.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA,
    input  logic                      HOLD,
    output logic [NUM_REQ-1:0]        ACK,
    output logic [(2**ADDR_W)-1:0]    LOAD,
    output logic [DATA_W-1:0]         WDATA,
    output logic                      BUSY
);

    localparam int unsigned IDX_W    = idx_width(NUM_REQ);
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    state_t                 state;
    logic [IDX_W-1:0]       ptr;
    logic [NUM_REQ-1:0]     ack_q;
    logic [NUM_REGS-1:0]    load_q;
    logic [DATA_W-1:0]      wdata_q;
    logic                   busy_q;

    logic [NUM_REQ-1:0]     elig_c;
    logic                   pick_valid_c;
    logic [IDX_W-1:0]       pick_idx_c;
    logic [ADDR_W-1:0]      sel_addr_c;
    logic [DATA_W-1:0]      sel_data_c;
    logic [NUM_REGS-1:0]    load_dec_c;
    logic [NUM_REQ-1:0]     ack_dec_c;
    logic [IDX_W-1:0]       ptr_next_c;

    // Eligible requesters: HOLD blocks all, and the one being acked now sits out.
    always_comb begin
        elig_c = HOLD ? '0 : (REQ & ~ack_q);
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .mask  (elig_c),
        .ptr   (ptr),
        .valid (pick_valid_c),
        .idx   (pick_idx_c)
    );

    // Select the winner's address and data slices.
    always_comb begin
        sel_addr_c = '0;
        sel_data_c = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (pick_idx_c == IDX_W'(i)) begin
                sel_addr_c = REQ_ADDR[i*ADDR_W +: ADDR_W];
                sel_data_c = REQ_DATA[i*DATA_W +: DATA_W];
            end
        end
    end

    // One-hot load decoder; R0 is hardwired to zero so it never gets a load.
    always_comb begin
        load_dec_c = '0;
        for (int r = 1; r < int'(NUM_REGS); r++) begin
            load_dec_c[r] = (sel_addr_c == ADDR_W'(r));
        end
    end

    // One-hot ACK for the winner and the pointer just past it (with wrap).
    always_comb begin
        ack_dec_c = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            ack_dec_c[i] = (pick_idx_c == IDX_W'(i));
        end
        if (pick_idx_c == IDX_W'(NUM_REQ - 1)) begin
            ptr_next_c = '0;
        end else begin
            ptr_next_c = pick_idx_c + IDX_W'(1);
        end
    end

    // Arbiter FSM with registered write outputs; grants may chain back-to-back.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            ptr     <= '0;
            ack_q   <= '0;
            load_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid_c) begin
                        state   <= WRITE;
                        ptr     <= ptr_next_c;
                        ack_q   <= ack_dec_c;
                        load_q  <= load_dec_c;
                        wdata_q <= sel_data_c;
                        busy_q  <= 1'b1;
                    end
                end
                WRITE: begin
                    if (pick_valid_c) begin
                        state   <= WRITE;
                        ptr     <= ptr_next_c;
                        ack_q   <= ack_dec_c;
                        load_q  <= load_dec_c;
                        wdata_q <= sel_data_c;
                        busy_q  <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        ack_q   <= '0;
                        load_q  <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ack_q   <= '0;
                    load_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Drive ports straight from the output registers.
    always_comb begin
        ACK   = ack_q;
        LOAD  = load_q;
        WDATA = wdata_q;
        BUSY  = busy_q;
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a vector table for the cycle-by-cycle
// grant sequences plus hand-written reset sequences.
module tb_rf_write_arbiter;

    logic        CLK;
    logic        RST;
    logic [2:0]  REQ;
    logic [14:0] REQ_ADDR;
    logic [95:0] REQ_DATA;
    logic        HOLD;
    logic [2:0]  ACK;
    logic [31:0] LOAD;
    logic [31:0] WDATA;
    logic        BUSY;

    logic [4:0]  a2;
    logic [31:0] d2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  req;
        logic        hold;
        logic [4:0]  a2;
        logic [31:0] d2;
        logic [2:0]  ack;
        logic [31:0] load;
        logic [31:0] wdata;
        logic        busy;
    } vec_t;

    vec_t vt[$];

    rf_write_arbiter dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ      (REQ),
        .REQ_ADDR (REQ_ADDR),
        .REQ_DATA (REQ_DATA),
        .HOLD     (HOLD),
        .ACK      (ACK),
        .LOAD     (LOAD),
        .WDATA    (WDATA),
        .BUSY     (BUSY)
    );

    // Requester 0: R5 / DEADBEEF, requester 1: R9 / 11111111, requester 2: variable.
    always_comb begin
        REQ_ADDR = {a2, 5'd9, 5'd5};
        REQ_DATA = {d2, 32'h1111_1111, 32'hDEAD_BEEF};
    end

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] e_ack, input logic [31:0] e_load,
                           input logic [31:0] e_wdata, input logic e_busy);
        chk({tag, " ACK"},   32'(ACK),   32'(e_ack));
        chk({tag, " LOAD"},  LOAD,       e_load);
        chk({tag, " WDATA"}, WDATA,      e_wdata);
        chk({tag, " BUSY"},  32'(BUSY),  32'(e_busy));
    endtask

    function automatic vec_t mk(input logic [2:0] req, input logic hold, input logic [4:0] va2,
                                input logic [31:0] vd2, input logic [2:0] ack,
                                input logic [31:0] load, input logic [31:0] wdata,
                                input logic busy);
        vec_t v;
        v.req = req; v.hold = hold; v.a2 = va2; v.d2 = vd2;
        v.ack = ack; v.load = load; v.wdata = wdata; v.busy = busy;
        return v;
    endfunction

    localparam logic [31:0] L5  = 32'h0000_0020;
    localparam logic [31:0] L9  = 32'h0000_0200;
    localparam logic [31:0] L31 = 32'h8000_0000;
    localparam logic [31:0] DA  = 32'hDEAD_BEEF;
    localparam logic [31:0] DB  = 32'h1111_1111;
    localparam logic [31:0] DC  = 32'h2222_2222;
    localparam logic [31:0] DF  = 32'hFFFF_FFFF;

    initial begin
        // Three-way contention straight after reset: 0,1,2 then idle.
        vt.push_back(mk(3'b111, 0, 5'd31, DC, 3'b001, L5,  DA, 1));
        vt.push_back(mk(3'b110, 0, 5'd31, DC, 3'b010, L9,  DB, 1));
        vt.push_back(mk(3'b100, 0, 5'd31, DC, 3'b100, L31, DC, 1));
        vt.push_back(mk(3'b000, 0, 5'd31, DC, 3'b000, 0,   DC, 0));
        // Single write to R5.
        vt.push_back(mk(3'b001, 0, 5'd31, DC, 3'b001, L5,  DA, 1));
        vt.push_back(mk(3'b000, 0, 5'd31, DC, 3'b000, 0,   DA, 0));
        // Move pointer to 2, then fairness with wrap on REQ=011.
        vt.push_back(mk(3'b010, 0, 5'd31, DC, 3'b010, L9,  DB, 1));
        vt.push_back(mk(3'b000, 0, 5'd31, DC, 3'b000, 0,   DB, 0));
        vt.push_back(mk(3'b011, 0, 5'd31, DC, 3'b001, L5,  DA, 1));
        vt.push_back(mk(3'b011, 0, 5'd31, DC, 3'b010, L9,  DB, 1));
        vt.push_back(mk(3'b011, 0, 5'd31, DC, 3'b001, L5,  DA, 1));
        vt.push_back(mk(3'b011, 0, 5'd31, DC, 3'b010, L9,  DB, 1));
        vt.push_back(mk(3'b000, 0, 5'd31, DC, 3'b000, 0,   DB, 0));
        // Write to R0: acked, no load.
        vt.push_back(mk(3'b100, 0, 5'd0,  DF, 3'b100, 0,   DF, 1));
        vt.push_back(mk(3'b000, 0, 5'd0,  DF, 3'b000, 0,   DF, 0));
        // HOLD blocks requester 1 for four cycles, then it wins.
        vt.push_back(mk(3'b010, 1, 5'd0,  DF, 3'b000, 0,   DF, 0));
        vt.push_back(mk(3'b010, 1, 5'd0,  DF, 3'b000, 0,   DF, 0));
        vt.push_back(mk(3'b010, 1, 5'd0,  DF, 3'b000, 0,   DF, 0));
        vt.push_back(mk(3'b010, 1, 5'd0,  DF, 3'b000, 0,   DF, 0));
        vt.push_back(mk(3'b010, 0, 5'd0,  DF, 3'b010, L9,  DB, 1));
        vt.push_back(mk(3'b000, 0, 5'd0,  DF, 3'b000, 0,   DB, 0));
        // HOLD rising during WRITE suppresses only the next grant.
        vt.push_back(mk(3'b101, 0, 5'd31, DC, 3'b100, L31, DC, 1));
        vt.push_back(mk(3'b001, 1, 5'd31, DC, 3'b000, 0,   DC, 0));
        vt.push_back(mk(3'b001, 0, 5'd31, DC, 3'b001, L5,  DA, 1));
        vt.push_back(mk(3'b000, 0, 5'd31, DC, 3'b000, 0,   DA, 0));

        RST  = 1'b0;
        REQ  = '0;
        HOLD = 1'b0;
        a2   = 5'd31;
        d2   = DC;

        #2;
        chk_all("reset_state", 3'b000, 32'h0, 32'h0, 1'b0);
        #10;
        RST = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            REQ  = vt[i].req;
            HOLD = vt[i].hold;
            a2   = vt[i].a2;
            d2   = vt[i].d2;
            @(posedge CLK);
            #1;
            chk_all($sformatf("vec%0d", i), vt[i].ack, vt[i].load, vt[i].wdata, vt[i].busy);
        end

        // Reset mid-WRITE: outputs clear asynchronously, write is discarded.
        REQ = 3'b001;
        @(posedge CLK);
        #1;
        chk_all("pre_reset_write", 3'b001, L5, DA, 1'b1);
        REQ = 3'b011;
        #1;
        RST = 1'b0;
        #1;
        chk_all("async_reset", 3'b000, 32'h0, 32'h0, 1'b0);
        // Requests held through reset edges must not be granted.
        @(posedge CLK);
        #1;
        chk_all("in_reset", 3'b000, 32'h0, 32'h0, 1'b0);
        REQ = 3'b000;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk_all("post_release", 3'b000, 32'h0, 32'h0, 1'b0);
        // Pointer back at 0: requester 0 wins over 1.
        REQ = 3'b011;
        @(posedge CLK);
        #1;
        chk_all("ptr_after_reset", 3'b001, L5, DA, 1'b1);
        REQ = 3'b010;
        @(posedge CLK);
        #1;
        chk_all("ptr_after_reset_2", 3'b010, L9, DB, 1'b1);
        REQ = 3'b000;
        @(posedge CLK);
        #1;
        chk_all("final_idle", 3'b000, 32'h0, DB, 1'b0);

        // Reset held during a request: first grant on the first edge after release.
        REQ = 3'b100;
        a2  = 5'd31;
        d2  = DC;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk_all("req_during_reset", 3'b000, 32'h0, 32'h0, 1'b0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk_all("first_grant", 3'b100, L31, DC, 1'b1);
        REQ = 3'b000;
        @(posedge CLK);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
